// File: rtl/avg_pipe_if.sv
// Stream bundle for avg_pipe: sample beats in, block means out.
// master = producer/consumer side, slave = the averager.
interface avg_pipe_if #(
    parameter int DATA_W     = 8,
    parameter int LANES_LOG2 = 3
);
    localparam int LANES = 1 << LANES_LOG2;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       avg;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, avg
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, avg
    );
endinterface

// File: rtl/avg_pipe.sv
// Streaming block averager: LANES samples per beat, 2^BEATS_LOG2 beats per block,
// three-stage pipeline (lane sum, accumulate, rounded/truncated output register).
module avg_pipe #(
    parameter int DATA_W     = 8,
    parameter int LANES_LOG2 = 3,
    parameter int BEATS_LOG2 = 5,
    parameter int ROUND      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    avg_pipe_if.slave  bus
);
    localparam int LANES = 1 << LANES_LOG2;
    localparam int SHIFT = LANES_LOG2 + BEATS_LOG2;
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int SUM_W = DATA_W + LANES_LOG2;
    localparam logic [ACC_W-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? ACC_W'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;

    logic                  adv;
    logic                  xfer;
    logic [BEATS_LOG2-1:0] beat_cnt;
    logic [SUM_W-1:0]      lane_sum;
    logic [SUM_W-1:0]      s1_sum;
    logic                  s1_valid;
    logic                  s1_first;
    logic                  s1_last;
    logic [ACC_W-1:0]      acc;
    logic                  s2_done;
    logic [DATA_W-1:0]     avg_next;
    logic                  out_valid_q;
    logic [DATA_W-1:0]     avg_q;

    // Whole pipeline freezes only while a result sits unaccepted at the output.
    assign adv          = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv && !rst && !clear;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.avg       = avg_q;

    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SUM_W'(bus.in_data[k*DATA_W +: DATA_W]);
        end
    end

    // Rounding addend cannot carry out: (2^D-1)*2^S + 2^(S-1) < 2^(D+S).
    assign avg_next = DATA_W'((acc + RND) >> SHIFT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else if (adv) begin
            s1_valid <= xfer;
            s1_first <= (beat_cnt == '0);
            s1_last  <= (beat_cnt == '1);
            s1_sum   <= lane_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            s2_done <= 1'b0;
        end else if (clear) begin
            s2_done <= 1'b0;
        end else if (adv) begin
            s2_done <= s1_valid && s1_last;
            if (s1_valid) begin
                acc <= s1_first ? ACC_W'(s1_sum) : acc + ACC_W'(s1_sum);
            end
        end
    end

    // A finished block still in stage 2 is dropped by clear; the output register is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            avg_q       <= '0;
        end else if (s2_done && adv && !clear) begin
            out_valid_q <= 1'b1;
            avg_q       <= avg_next;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_avg_pipe.sv
// Bench for avg_pipe: table of whole-block vectors, hand sequences for stall/clear/reset,
// and random traffic against a block-sum scoreboard (ROUND=1 and ROUND=0 builds side by side).
module tb_avg_pipe;
    localparam int DATA_W     = 8;
    localparam int LANES_LOG2 = 3;
    localparam int BEATS_LOG2 = 5;
    localparam int LANES      = 1 << LANES_LOG2;
    localparam int BEATS      = 1 << BEATS_LOG2;
    localparam int SAMPLES    = LANES * BEATS;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    avg_pipe_if #(.DATA_W(DATA_W), .LANES_LOG2(LANES_LOG2)) bus_r ();
    avg_pipe_if #(.DATA_W(DATA_W), .LANES_LOG2(LANES_LOG2)) bus_t ();

    assign bus_t.in_valid  = bus_r.in_valid;
    assign bus_t.in_data   = bus_r.in_data;
    assign bus_t.out_ready = bus_r.out_ready;

    avg_pipe #(.DATA_W(DATA_W), .LANES_LOG2(LANES_LOG2), .BEATS_LOG2(BEATS_LOG2), .ROUND(1))
        dut_r (.clk(clk), .rst(rst), .clear(clear), .bus(bus_r));
    avg_pipe #(.DATA_W(DATA_W), .LANES_LOG2(LANES_LOG2), .BEATS_LOG2(BEATS_LOG2), .ROUND(0))
        dut_t (.clk(clk), .rst(rst), .clear(clear), .bus(bus_t));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: averages from the plain sum of every accepted sample of a block.
    typedef struct { int r; int t; } res_t;
    res_t    exp_q[$];
    res_t    exp_e;
    int      m_cnt = 0;
    longint  m_sum = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_sum = 0;
            exp_q.delete();
        end else begin
            if (bus_r.out_valid && bus_r.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("sb_avg_round", bus_r.avg, exp_e.r);
                    chk("sb_avg_trunc", bus_t.avg, exp_e.t);
                    chk("sb_valid_trunc", bus_t.out_valid, 1);
                end
            end
            if (clear) begin
                m_cnt = 0;
                m_sum = 0;
            end else if (bus_r.in_valid && bus_r.in_ready) begin
                for (int k = 0; k < LANES; k++) m_sum += bus_r.in_data[k*DATA_W +: DATA_W];
                m_cnt++;
                if (m_cnt == BEATS) begin
                    exp_e.r = int'((m_sum + SAMPLES / 2) / SAMPLES);
                    exp_e.t = int'(m_sum / SAMPLES);
                    exp_q.push_back(exp_e);
                    m_cnt = 0;
                    m_sum = 0;
                end
            end
        end
    end

    // Event log for the multi-cycle sequences.
    bit log_en = 0;
    int res_val[$];
    int res_cyc[$];
    int ov_cycles;
    int rdy_drops;

    always @(negedge clk) begin
        if (log_en) begin
            if (bus_r.out_valid) ov_cycles++;
            if (bus_r.out_valid && bus_r.out_ready) begin
                res_val.push_back(int'(bus_r.avg));
                res_cyc.push_back(cyc);
            end
            if (bus_r.in_valid && !bus_r.in_ready) rdy_drops++;
        end
    end

    task automatic log_reset();
        res_val.delete();
        res_cyc.delete();
        ov_cycles = 0;
        rdy_drops = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*DATA_W-1:0] fill(input logic [DATA_W-1:0] v);
        return {LANES{v}};
    endfunction

    // Present one beat and return in the cycle after it transferred.
    task automatic send_beat(input logic [LANES*DATA_W-1:0] d);
        int n;
        bus_r.in_valid = 1'b1;
        bus_r.in_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus_r.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_beat_timeout", 0, 1);
        step();
    endtask

    task automatic send_fill_block(input logic [DATA_W-1:0] v);
        for (int b = 0; b < BEATS; b++) send_beat(fill(v));
    endtask

    task automatic run_block(input string nm, input logic [7:0] fv, input bit sp,
                             input logic [7:0] sv, input int er, input int et);
        logic [LANES*DATA_W-1:0] d;
        int lat;
        for (int b = 0; b < BEATS; b++) begin
            d = fill(fv);
            if (sp && b == 0) d[7:0] = sv;
            send_beat(d);
        end
        bus_r.in_valid = 1'b0;
        lat = 1;
        while (!bus_r.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_avg_round"}, bus_r.avg, er);
        chk({nm, "_avg_trunc"}, bus_t.avg, et);
    endtask

    typedef struct {
        string     nm;
        logic [7:0] fill_v;
        bit         special;
        logic [7:0] spec_v;
        int         exp_r;
        int         exp_t;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c10;
        int t0;

        vecs[0] = '{"const80",   8'h80, 1'b0, 8'h00, 8'h80, 8'h80};
        vecs[1] = '{"constFF",   8'hFF, 1'b0, 8'h00, 8'hFF, 8'hFF};
        vecs[2] = '{"single128", 8'h00, 1'b1, 8'd128, 1,    0};
        vecs[3] = '{"single127", 8'h00, 1'b1, 8'd127, 0,    0};
        vecs[4] = '{"half_up",   8'h10, 1'b1, 8'h90, 8'h11, 8'h10};
        vecs[5] = '{"const33",   8'h33, 1'b0, 8'h00, 8'h33, 8'h33};

        rst = 1'b1;
        clear = 1'b0;
        bus_r.in_valid  = 1'b0;
        bus_r.in_data   = '0;
        bus_r.out_ready = 1'b1;
        step();
        step();
        chk("reset_out_valid", bus_r.out_valid, 0);
        chk("reset_avg", bus_r.avg, 0);
        chk("reset_in_ready", bus_r.in_ready, 0);
        chk("reset_out_valid_trunc", bus_t.out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", bus_r.in_ready, 1);

        foreach (vecs[i])
            run_block(vecs[i].nm, vecs[i].fill_v, vecs[i].special, vecs[i].spec_v,
                      vecs[i].exp_r, vecs[i].exp_t);
        step();

        // Back-to-back blocks, no output stall.
        log_reset();
        log_en = 1;
        t0 = cyc;
        send_fill_block(8'd10);
        send_fill_block(8'd20);
        chk("b2b_beat_cycles", cyc - t0, 64);
        bus_r.in_valid = 1'b0;
        repeat (8) step();
        log_en = 0;
        chk("b2b_in_ready_drops", rdy_drops, 0);
        chk("b2b_result_count", res_val.size(), 2);
        if (res_val.size() == 2) begin
            chk("b2b_first_avg", res_val[0], 10);
            chk("b2b_second_avg", res_val[1], 20);
            chk("b2b_spacing", res_cyc[1] - res_cyc[0], 32);
        end
        chk("b2b_out_valid_cycles", ov_cycles, 2);

        // Same blocks with a 5-cycle output stall on the first result.
        c10 = 0;
        fork
            begin
                send_fill_block(8'd10);
                send_fill_block(8'd20);
                bus_r.in_valid = 1'b0;
            end
            begin
                n = 0;
                while (!bus_r.out_valid && n < 100) begin
                    step();
                    n++;
                end
                chk("bp_first_seen", bus_r.out_valid, 1);
                c10 = cyc;
                bus_r.out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("bp_in_ready_low", bus_r.in_ready, 0);
                    chk("bp_avg_held", bus_r.avg, 10);
                    chk("bp_out_valid_held", bus_r.out_valid, 1);
                    step();
                end
                bus_r.out_ready = 1'b1;
                step();
                n = 0;
                while (!bus_r.out_valid && n < 100) begin
                    step();
                    n++;
                end
                chk("bp_second_delay", cyc - c10, 37);
                chk("bp_second_avg", bus_r.avg, 20);
            end
        join
        repeat (4) step();

        // Clear mid-block; the beat offered under clear must not count.
        for (int b = 0; b < 10; b++) send_beat(fill(8'hFF));
        bus_r.in_valid = 1'b1;
        bus_r.in_data  = fill(8'hFF);
        clear = 1'b1;
        #1;
        chk("clear_in_ready", bus_r.in_ready, 0);
        step();
        clear = 1'b0;
        log_reset();
        log_en = 1;
        run_block("after_clear", 8'd7, 1'b0, 8'h00, 7, 7);
        repeat (5) step();
        log_en = 0;
        chk("clear_result_count", res_val.size(), 1);

        // Reset in the middle of a block.
        for (int b = 0; b < 20; b++) send_beat(fill(8'h55));
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", bus_r.in_ready, 0);
        step();
        chk("midrst_out_valid", bus_r.out_valid, 0);
        chk("midrst_in_ready_held", bus_r.in_ready, 0);
        step();
        rst = 1'b0;
        bus_r.in_data = fill(8'h33);
        #1;
        chk("midrst_release_in_ready", bus_r.in_ready, 1);
        run_block("after_rst", 8'h33, 1'b0, 8'h00, 8'h33, 8'h33);
        step();

        // Reset discards an unaccepted result.
        bus_r.out_ready = 1'b0;
        send_fill_block(8'h44);
        bus_r.in_valid = 1'b0;
        n = 0;
        while (!bus_r.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("pending_valid", bus_r.out_valid, 1);
        chk("pending_avg", bus_r.avg, 8'h44);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("pending_dropped", bus_r.out_valid, 0);
        bus_r.out_ready = 1'b1;
        log_reset();
        log_en = 1;
        repeat (5) step();
        log_en = 0;
        chk("pending_no_result", res_val.size(), 0);

        // Random traffic with stalls and occasional clears mid-block.
        for (int c = 0; c < 2000; c++) begin
            bus_r.in_valid  = ($urandom_range(0, 9) < 8);
            bus_r.in_data   = {$urandom, $urandom};
            bus_r.out_ready = ($urandom_range(0, 3) != 0);
            clear = (m_cnt >= 2) && ($urandom_range(0, 149) == 0);
            step();
        end
        clear = 1'b0;
        bus_r.in_valid  = 1'b0;
        bus_r.out_ready = 1'b1;
        repeat (10) step();
        chk("random_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_pipe.md
# avg_pipe

Parametrised, fully pipelined block averager. It accepts `LANES` samples per beat over a valid/ready handshake and accumulates `2^BEATS_LOG2` beats per block. It emits one rounded or truncated mean per block on a valid/ready output. It replaces the fixed 8×32 mux-and-adder-tree averager: data is streamed in, not preloaded, and it adds back-to-back blocks, output backpressure and an abort input.

## Interface
- `DATA_W`, default 8: sample and result width, unsigned.
- `LANES_LOG2`, default 3: log2 of lanes per beat (LANES = 2^LANES_LOG2).
- `BEATS_LOG2`, default 5: log2 of beats per block.
- `ROUND`, default 1: 1 = round half up, 0 = truncate.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort of the block in progress.
- `in_valid`  in  1  beat on `in_data` is valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_data`  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- `out_valid`  out  1  `avg` holds a block result.
- `out_ready`  in  1  consumer accepts `avg` this cycle.
- `avg`  out  DATA_W  mean of the last completed block.

## Operation
- Derived constants: SHIFT = LANES_LOG2 + BEATS_LOG2; ACC_W = DATA_W + SHIFT. The accumulator cannot overflow.
- A beat transfers when `in_valid && in_ready`. A beat counter (BEATS_LOG2 bits) increments on each transfer and wraps to 0 after the last beat. Transfer at count 2^BEATS_LOG2−1 is tagged `last`; transfer at count 0 is tagged `first`.
- Stage 1 registers the LANES-input lane sum (DATA_W+LANES_LOG2 bits) with `first`/`last` tags and a stage valid.
- Stage 2 is the accumulator:
  - a `first` beat loads the lane sum, without adding;
  - any other valid beat adds it;
  - the `last` tag is carried to a done flag.
- Stage 3 is the output register. On done it loads `avg` and sets `out_valid`:
  - `avg = (acc + 2^(SHIFT−1)) >> SHIFT` when ROUND=1;
  - `avg = acc >> SHIFT` when ROUND=0.
- Result width is always exactly DATA_W, because the mean of N all-max samples is max in both modes.
- Output handshake: `out_valid` stays high and `avg` stays stable until `out_valid && out_ready`. If stage 2 delivers a new result in the same cycle one is accepted, the output reloads and `out_valid` stays high.
- Stall: `adv = !(out_valid && !out_ready)`. When `adv` is 0, stages 1–2 and the beat counter hold. `in_ready = adv && !rst && !clear`, which is a combinational path from `out_ready` to `in_ready`.
- `clear`:
  - zeroes the beat counter;
  - invalidates stages 1–2, including a `last` beat in flight;
  - drops any beat presented that cycle (`in_ready` is 0);
  - leaves a result already in the output register untouched.
- Next transfer after `clear` or `rst` is `first`.

## Timing
- Reset values: `out_valid`=0, `avg`=0, `in_ready`=0 while `rst` is high, beat counter=0, stage valids=0, accumulator=0.
- `in_ready` is 1 in the first cycle after `rst` falls, unless `clear` is high.
- Throughput is one beat per cycle with no bubble between blocks. The `first` beat of block n+1 may transfer the cycle after the `last` beat of block n.
- Latency, no stall: `last` beat transferred in cycle t → `out_valid`=1 with the correct `avg` in cycle t+3.
- Each stall cycle adds exactly one cycle to this latency. No data is lost or duplicated.
- With `out_ready` held at 1, `out_valid` is high for exactly one cycle per block.
- `rst` overrides `clear`, `in_valid` and `out_ready`. `rst` mid-block discards all state, including an unaccepted result.
- `clear` and `rst` both high: reset behaviour.

## Test plan
- All parameters at default (8 lanes × 32 beats = 256 samples).
- **Constant block:** `out_ready`=1; one block with every sample 0x80 → `avg`=0x80, `out_valid` exactly 3 cycles after the last beat. Repeat with all 0xFF → `avg`=0xFF, with no overflow.
- **Rounding boundary:** one block with a single sample of 128 and the rest 0 → `avg`=0x01 with ROUND=1. ROUND=0 build, same stimulus → `avg`=0x00. A single sample of 127 → 0x00 in both builds.
- **Back-to-back:** blocks of all 10 then all 20, streamed with `in_valid` held high for 64 cycles → `in_ready` never drops. Results 10 then 20 appear 32 cycles apart, each `out_valid` pulse one cycle wide.
- **Backpressure:** same two blocks, `out_ready` held at 0 from the first `out_valid` for 5 cycles:
  - `in_ready` is 0 throughout and `avg` stays 10 during that window;
  - after `out_ready` rises, the second result is 20, delayed by exactly 5 cycles.
- **Clear mid-block:** stream 10 beats of 0xFF, pulse `clear` with `in_valid`=1, then send a full block of all 7 → a single result of 7. The beat presented during `clear` is not counted.
- **Reset mid-operation:** assert `rst` after 20 beats of a block → `out_valid`=0 and `in_ready`=0 during reset. A fresh block of all 0x33 afterwards → `avg`=0x33.
